unpacker_block_arbiter: RTL and testbench

//  Shares the single byte_unpacker (128-bit block -> serial UART bytes) between NUM_REQ block sources
//  (ZMODEM header builder, data-subpacket path, CRC/trailer). Round-robin grant, optional channel lock
//  for multi-block frames, and a watchdog on the unpacker handshake. Sits between the sources and unpacker.

---
 rtl/unpacker_block_arbiter_pkg.sv | 19 +
 rtl/unpacker_block_arbiter_rr_pick.sv | 28 ++
 rtl/unpacker_block_arbiter.sv | 135 +++++++++++++
 tb/tb_unpacker_block_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unpacker_block_arbiter_pkg.sv
// Shared definitions for the unpacker block arbiter.
// FSM encodings, default block width and ZMODEM source indices.
package unpacker_block_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_LOAD       = 2'd1,
      S_WAIT_START = 2'd2,
      S_WAIT_DONE  = 2'd3
   } state_t;

   localparam int BLK_W_DEF = 128;
   localparam int GID_W     = 3;

   localparam int SRC_HDR  = 0;
   localparam int SRC_DATA = 1;
   localparam int SRC_CRC  = 2;

endpackage

// File: rtl/unpacker_block_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Search starts at i_ptr and wraps; first set request wins.
module rr_pick
   import unpacker_block_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [GID_W-1:0]   i_ptr,
   output logic [GID_W-1:0]   o_win,
   output logic               o_valid
);

   always_comb begin
      int idx;
      idx     = 0;
      o_win   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(i_ptr) + k) % NUM_REQ;
         if (!o_valid && i_req[idx]) begin
            o_valid = 1'b1;
            o_win   = GID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/unpacker_block_arbiter.sv
// Shares one byte_unpacker between NUM_REQ block sources:
// round-robin grant, frame lock and a start-handshake watchdog.
module unpacker_block_arbiter
   import unpacker_block_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int BLK_W     = BLK_W_DEF,
   parameter int START_TMO = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*BLK_W-1:0] req_block,
   input  logic [NUM_REQ-1:0]       req_hold,
   output logic [NUM_REQ-1:0]       ack,
   output logic [NUM_REQ-1:0]       blk_done,
   output logic [BLK_W-1:0]         plain_block,
   output logic                     load_en,
   input  logic                     buffer_ready,
   output logic [GID_W-1:0]         grant_id,
   output logic                     busy,
   output logic                     err_tmo
);

   localparam int CNT_W = $clog2(START_TMO + 1);

   state_t             r_state;
   state_t             w_next;
   logic [GID_W-1:0]   r_win;
   logic [GID_W-1:0]   r_ptr;
   logic [BLK_W-1:0]   r_block;
   logic               r_lock;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err;

   logic [NUM_REQ-1:0] w_win_oh;
   logic [NUM_REQ-1:0] w_elig;
   logic [GID_W-1:0]   w_win;
   logic               w_valid;
   logic [BLK_W-1:0]   w_sel_blk;
   logic               w_tmo;
   logic               w_grant;

   assign w_win_oh = NUM_REQ'(1) << r_win;
   // While locked, only the frame owner (last winner) may be picked
   assign w_elig   = r_lock ? (req & w_win_oh) : req;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req   (w_elig),
      .i_ptr   (r_ptr),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   always_comb begin
      w_sel_blk = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == GID_W'(i)) begin
            w_sel_blk = req_block[i*BLK_W +: BLK_W];
         end
      end
   end

   assign w_tmo = (r_state == S_WAIT_START) && buffer_ready &&
                  (r_cnt == CNT_W'(START_TMO - 1));
   assign w_grant = (r_state == S_IDLE) && buffer_ready && w_valid;

   always_comb begin
      w_next   = r_state;
      load_en  = 1'b0;
      ack      = '0;
      blk_done = '0;
      unique case (r_state)
         S_IDLE: begin
            if (w_grant) w_next = S_LOAD;
         end
         S_LOAD: begin
            load_en = 1'b1;
            ack     = w_win_oh;
            w_next  = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (!buffer_ready) w_next = S_WAIT_DONE;
            else if (w_tmo)    w_next = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (buffer_ready) begin
               blk_done = w_win_oh;
               w_next   = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign busy        = (r_state != S_IDLE);
   assign grant_id    = r_win;
   assign plain_block = r_block;
   assign err_tmo     = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_win   <= '0;
         r_ptr   <= '0;
         r_block <= '0;
         r_lock  <= 1'b0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_win   <= w_win;
            r_block <= w_sel_blk;
         end
         if (r_state == S_LOAD) begin
            r_lock <= |(req_hold & w_win_oh);
            r_ptr  <= (r_win == GID_W'(NUM_REQ - 1)) ? '0 : r_win + GID_W'(1);
         end
         // Counts from the load cycle so the timeout lands START_TMO after load_en
         if (r_state == S_LOAD || r_state == S_WAIT_START) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= '0;
         end
         if (w_tmo) begin
            r_err  <= 1'b1;
            r_lock <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_unpacker_block_arbiter.sv
// Bench for unpacker_block_arbiter with a behavioural unpacker model.
// Directed vector table, corner sequences and a random scoreboard run.
module tb_unpacker_block_arbiter;
   import unpacker_block_arbiter_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic [2:0]   req;
   logic [2:0]   req_hold;
   logic [127:0] blk [3];
   logic [383:0] req_block;
   logic [2:0]   ack;
   logic [2:0]   blk_done;
   logic [127:0] plain_block;
   logic         load_en;
   logic         buffer_ready;
   logic [2:0]   grant_id;
   logic         busy;
   logic         err_tmo;

   logic br = 1'b1;
   bit   tmo_mode = 1'b0;
   bit   force_low = 1'b0;
   int   bcnt = 0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0] req;
      logic [2:0] hold;
      logic [2:0] win;
   } vec_t;
   vec_t tbl [11];

   always #5 clk = ~clk;

   assign req_block    = {blk[2], blk[1], blk[0]};
   assign buffer_ready = br & ~force_low;

   unpacker_block_arbiter dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_block    (req_block),
      .req_hold     (req_hold),
      .ack          (ack),
      .blk_done     (blk_done),
      .plain_block  (plain_block),
      .load_en      (load_en),
      .buffer_ready (buffer_ready),
      .grant_id     (grant_id),
      .busy         (busy),
      .err_tmo      (err_tmo)
   );

   // Unpacker: goes busy right after load_en, idle again 18 cycles later
   always begin
      @(posedge clk);
      #1;
      if (reset) begin
         br   = 1'b1;
         bcnt = 0;
      end else if (load_en && !tmo_mode) begin
         br   = 1'b0;
         bcnt = 18;
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) br = 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      req      = '0;
      req_hold = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ack"}, ack, 0);
      chk({nm, "_done"}, blk_done, 0);
      chk({nm, "_blk"}, plain_block, 0);
      chk({nm, "_load"}, load_en, 0);
      chk({nm, "_gid"}, grant_id, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_tmo"}, err_tmo, 0);
   endtask

   task automatic wait_done(input string nm, input logic [2:0] ew);
      int n;
      n = 0;
      while (blk_done == 3'b000 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_done_lat"}, n, 18);
      chk({nm, "_done"}, blk_done, 3'b001 << ew);
   endtask

   // Entered at a drive point with the arbiter idle; leaves it idle again
   task automatic grant_step(input string nm, input logic [2:0] r,
                             input logic [2:0] h, input logic [2:0] ew);
      req      = r;
      req_hold = h;
      @(negedge clk);
      chk({nm, "_early"}, load_en, 0);
      @(negedge clk);
      chk({nm, "_load"}, load_en, 1);
      chk({nm, "_gid"}, grant_id, ew);
      chk({nm, "_ack"}, ack, 3'b001 << ew);
      chk({nm, "_blk"}, plain_block, blk[ew]);
      chk({nm, "_busy"}, busy, 1);
      wait_done(nm, ew);
      blk[ew] = {$urandom, $urandom, $urandom, $urandom};
      tick();
   endtask

   initial begin
      int   nl;
      bit   seen;
      int   ptr, lsrc, exp_win, cur_win, since;
      bit   lock, outst, exp_load;
      bit [2:0] ackd;
      logic [2:0] cand;

      tbl[0]  = '{3'b111, 3'b000, 3'd0};
      tbl[1]  = '{3'b111, 3'b000, 3'd1};
      tbl[2]  = '{3'b111, 3'b000, 3'd2};
      tbl[3]  = '{3'b111, 3'b000, 3'd0};
      tbl[4]  = '{3'b001, 3'b001, 3'd0};
      tbl[5]  = '{3'b101, 3'b001, 3'd0};
      tbl[6]  = '{3'b101, 3'b000, 3'd0};
      tbl[7]  = '{3'b101, 3'b000, 3'd2};
      tbl[8]  = '{3'b110, 3'b000, 3'd1};
      tbl[9]  = '{3'b011, 3'b000, 3'd0};
      tbl[10] = '{3'b010, 3'b010, 3'd1};

      for (int i = 0; i < 3; i++)
         blk[i] = {$urandom, $urandom, $urandom, $urandom};
      reset    = 1'b1;
      req      = '0;
      req_hold = '0;
      repeat (3) tick();
      @(negedge clk);
      chk_zero("reset");
      tick();
      reset = 1'b0;

      blk[SRC_DATA] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      grant_step("single", 3'b010, 3'b000, 3'd1);
      req = '0;
      do_reset();

      for (int i = 0; i < 11; i++)
         grant_step($sformatf("vec%0d", i), tbl[i].req, tbl[i].hold, tbl[i].win);

      // Locked owner idle: other sources must starve
      req      = 3'b100;
      req_hold = 3'b000;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen |= load_en;
      end
      chk("lock_starve", seen, 0);
      tick();
      grant_step("lock_resume", 3'b110, 3'b000, 3'd1);

      // Watchdog: unpacker never leaves idle
      tmo_mode = 1'b1;
      req      = 3'b100;
      req_hold = 3'b100;
      @(negedge clk);
      @(negedge clk);
      chk("tmo_load", load_en, 1);
      chk("tmo_gid", grant_id, 2);
      tick();
      req      = 3'b001;
      req_hold = 3'b000;
      tmo_mode = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (k > 1) @(negedge clk);
         else @(negedge clk);
         seen |= (blk_done != 3'b000);
         if (k == 14) begin
            chk("tmo_err_early", err_tmo, 0);
            chk("tmo_busy_early", busy, 1);
         end
         if (k == 15) begin
            chk("tmo_err", err_tmo, 1);
            chk("tmo_busy", busy, 0);
         end
      end
      chk("tmo_no_done", seen, 0);
      @(negedge clk);
      chk("tmo_next_load", load_en, 1);
      chk("tmo_next_gid", grant_id, 0);
      wait_done("tmo_next", 3'd0);
      chk("tmo_sticky", err_tmo, 1);
      tick();

      // Reset while the unpacker is mid-block
      req      = 3'b010;
      req_hold = 3'b000;
      @(negedge clk);
      @(negedge clk);
      chk("rst_load", load_en, 1);
      repeat (5) @(negedge clk);
      chk("rst_busy", busy, 1);
      tick();
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      @(negedge clk);
      chk_zero("rst_mid");
      tick();
      reset = 1'b0;

      // Unpacker not ready while idle: no grant
      force_low = 1'b1;
      req       = 3'b100;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen |= load_en;
      end
      chk("notready_noload", seen, 0);
      tick();
      force_low = 1'b0;
      @(negedge clk);
      chk("notready_early", load_en, 0);
      @(negedge clk);
      chk("notready_load", load_en, 1);
      chk("notready_gid", grant_id, 2);
      wait_done("notready", 3'd2);
      tick();

      // Random traffic against a scoreboard
      do_reset();
      ptr = 0; lock = 0; lsrc = 0; outst = 0; exp_load = 0;
      exp_win = 0; cur_win = 0; since = 0; ackd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (req[i] && ackd[i]) begin
               req[i]  = 1'b0;
               ackd[i] = 1'b0;
            end else if (!req[i] && $urandom_range(3) == 0) begin
               req[i]      = 1'b1;
               blk[i]      = {$urandom, $urandom, $urandom, $urandom};
               req_hold[i] = ($urandom_range(2) == 0);
            end
         end
         @(negedge clk);
         chk("rnd_load", load_en, exp_load);
         chk("rnd_ack", ack, exp_load ? (3'b001 << exp_win) : 3'b000);
         if (exp_load) begin
            chk("rnd_gid", grant_id, exp_win);
            chk("rnd_blk", plain_block, blk[exp_win]);
            ackd[exp_win] = 1'b1;
            outst   = 1'b1;
            cur_win = exp_win;
            lock    = req_hold[exp_win];
            lsrc    = exp_win;
            ptr     = (exp_win + 1) % 3;
            since   = 0;
         end else begin
            since++;
         end
         chk("rnd_busy", busy, outst);
         chk("rnd_done", blk_done,
             (outst && since == 18) ? (3'b001 << cur_win) : 3'b000);
         exp_load = 1'b0;
         if (!outst && buffer_ready) begin
            cand = lock ? (req & (3'b001 << lsrc)) : req;
            for (int k = 0; k < 3; k++) begin
               if (!exp_load && cand[(ptr + k) % 3]) begin
                  exp_load = 1'b1;
                  exp_win  = (ptr + k) % 3;
               end
            end
         end
         if (outst && since == 18) outst = 1'b0;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
